// File: rtl/time_display_scan_if.sv
// Display-side bundle for time_display_scan: BCD time and enable in, multiplexed
// 7-segment drive out. No handshake; outputs are free-running scan signals.
interface time_display_scan_if;
  logic [23:0] time_data;
  logic        en;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  dig;
  logic [2:0]  digit_idx;

  modport master (output time_data, en, input seg, dp, dig, digit_idx);
  modport slave  (input time_data, en, output seg, dp, dig, digit_idx);
endinterface

// File: rtl/time_display_scan.sv
// Six-digit multiplexed 7-segment time display scanner; DISP_DP_BLINK_EN adds dp blinking.
// Outputs registered, 1-cycle latency after each scan tick; no backpressure (free-running).
module time_display_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  time_display_scan_if.slave   bus
);

  localparam int              CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic            POL     = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]      SEG_OFF = {7{POL}};
  localparam logic [5:0]      DIG_OFF = {6{POL}};
  localparam logic            DP_OFF  = POL;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    dig_q, dig_d;
  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic [6:0]    seg_on;
  logic          dp_on;
  logic [5:0]    dig_on;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h00;
    endcase
  endfunction

`ifdef DISP_DP_BLINK_EN
  logic dp_phase_q, dp_phase_d;

  // Phase flips only when the captured seconds digit actually changes.
  always_comb begin
    dp_phase_d = dp_phase_q;
    if (wrap && (bus.time_data[3:0] != snap_q[3:0])) begin
      dp_phase_d = ~dp_phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_phase_q <= 1'b0;
    end else begin
      dp_phase_q <= dp_phase_d;
    end
  end
`endif

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    wrap   = tick && (idx_q == 3'd5);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    snap_d = wrap ? bus.time_data : snap_q;

    // Decode from next-state values so the new digit appears together with its index.
    nib    = 4'(snap_d >> {idx_d, 2'b00});
    seg_on = bcd_to_seg(nib);
    if ((idx_d == 3'd5) && (nib == 4'd0)) begin
      seg_on = 7'h00;
    end
`ifdef DISP_DP_BLINK_EN
    dp_on  = ((idx_d == 3'd2) || (idx_d == 3'd4)) && dp_phase_d;
`else
    dp_on  = (idx_d == 3'd2) || (idx_d == 3'd4);
`endif
    dig_on = 6'b000001 << idx_d;

    seg_d = seg_q;
    dp_d  = dp_q;
    dig_d = dig_q;
    if (!bus.en) begin
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
      dig_d = DIG_OFF;
    end else if (tick) begin
      seg_d = seg_on ^ SEG_OFF;
      dp_d  = dp_on ^ DP_OFF;
      dig_d = dig_on ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      snap_q <= 24'h0;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      dig_q  <= DIG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.dig       = dig_q;
  assign bus.digit_idx = idx_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench: an active-high and an active-low instance (SCAN_DIV=4) run in lockstep.
module tb_time_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] td  = 24'h0;
  logic        en  = 1'b1;
  int          pass_cnt = 0;
  int          total    = 0;

  time_display_scan_if if0 ();
  time_display_scan_if if1 ();

  assign if0.time_data = td;
  assign if0.en        = en;
  assign if1.time_data = td;
  assign if1.en        = en;

  time_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(0)) u_hi (.clk(clk), .rst(rst), .bus(if0.slave));
  time_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) u_lo (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] td;
    logic [2:0]  idx;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Waits for digit_idx to change; returns at the negedge right after the tick update.
  task automatic next_tick();
    logic [2:0] prev;
    bit         seen;
    prev = if0.digit_idx;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (if0.digit_idx !== prev) seen = 1'b1;
    end
    check("tick_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic add(input logic [23:0] t, input logic [2:0] i, input logic [6:0] s, input logic d);
    vec_t v;
    v.td = t; v.idx = i; v.seg = s; v.dp = d;
    vq.push_back(v);
  endtask

  initial begin
    logic [5:0]  exp_dig;
    logic [23:0] blink_td [4];
    logic        blink_dp [4];

    // Post-reset frame: snapshot is zero, digit 5 blanked.
    add(24'h000000, 3'd1, 7'h3F, 1'b0);
    add(24'h000000, 3'd2, 7'h3F, 1'b1);
    add(24'h000000, 3'd3, 7'h3F, 1'b0);
    add(24'h000000, 3'd4, 7'h3F, 1'b1);
    add(24'h000000, 3'd5, 7'h00, 1'b0);
    add(24'h123456, 3'd0, 7'h7D, 1'b0);
    add(24'h123456, 3'd1, 7'h6D, 1'b0);
    add(24'h123456, 3'd2, 7'h66, 1'b1);
    add(24'h123456, 3'd3, 7'h4F, 1'b0);
    add(24'h123456, 3'd4, 7'h5B, 1'b1);
    add(24'h123456, 3'd5, 7'h06, 1'b0);
    add(24'h095900, 3'd0, 7'h3F, 1'b0);
    add(24'h095900, 3'd1, 7'h3F, 1'b0);
    add(24'h095900, 3'd2, 7'h6F, 1'b1);
    add(24'h095900, 3'd3, 7'h6D, 1'b0);
    add(24'h095900, 3'd4, 7'h6F, 1'b1);
    add(24'h095900, 3'd5, 7'h00, 1'b0);
    // time_data changes mid-frame: remaining digits still come from the old snapshot.
    add(24'h000000, 3'd0, 7'h3F, 1'b0);
    add(24'h000000, 3'd1, 7'h3F, 1'b0);
    add(24'h000000, 3'd2, 7'h3F, 1'b1);
    add(24'h111111, 3'd3, 7'h3F, 1'b0);
    add(24'h111111, 3'd4, 7'h3F, 1'b1);
    add(24'h111111, 3'd5, 7'h00, 1'b0);
    for (int i = 0; i < 6; i++) add(24'h111111, 3'(i), 7'h06, (i == 2 || i == 4));
    for (int i = 0; i < 6; i++) add(24'hABCDEF, 3'(i), 7'h00, (i == 2 || i == 4));

    repeat (3) @(negedge clk);
    check("rst_dig_hi", {26'd0, if0.dig}, 32'h00);
    check("rst_seg_hi", {25'd0, if0.seg}, 32'h00);
    check("rst_dp_hi",  {31'd0, if0.dp},  32'h0);
    check("rst_idx",    {29'd0, if0.digit_idx}, 32'h0);
    check("rst_seg_lo", {25'd0, if1.seg}, 32'h7F);
    check("rst_dig_lo", {26'd0, if1.dig}, 32'h3F);
    rst = 1'b0;

    foreach (vq[k]) begin
      td = vq[k].td;
      next_tick();
      exp_dig = 6'b000001 << vq[k].idx;
      check("tbl_idx",    {29'd0, if0.digit_idx}, {29'd0, vq[k].idx});
      check("tbl_dig_hi", {26'd0, if0.dig}, {26'd0, exp_dig});
      check("tbl_seg_hi", {25'd0, if0.seg}, {25'd0, vq[k].seg});
      check("tbl_dig_lo", {26'd0, if1.dig}, {26'd0, ~exp_dig});
      check("tbl_seg_lo", {25'd0, if1.seg}, {25'd0, ~vq[k].seg});
`ifndef DISP_DP_BLINK_EN
      check("tbl_dp_hi",  {31'd0, if0.dp}, {31'd0, vq[k].dp});
      check("tbl_dp_lo",  {31'd0, if1.dp}, {31'd0, ~vq[k].dp});
`endif
    end

    // Display disable for 10 cycles starting just after index 2 appears.
    for (int i = 0; i < 7 && if0.digit_idx != 3'd2; i++) next_tick();
    check("en_sync_idx", {29'd0, if0.digit_idx}, 32'd2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("en_off_dig_hi", {26'd0, if0.dig}, 32'h00);
      check("en_off_dig_lo", {26'd0, if1.dig}, 32'h3F);
    end
    en = 1'b1;
    @(negedge clk);
    check("en_resume_wait", {26'd0, if0.dig}, 32'h00);
    @(negedge clk);
    check("en_resume_idx", {29'd0, if0.digit_idx}, 32'd5);
    check("en_resume_dig", {26'd0, if0.dig}, 32'h20);

    // Reset pulsed at index 4 discards the frame.
    for (int i = 0; i < 7 && if0.digit_idx != 3'd4; i++) next_tick();
    check("rst_sync_idx", {29'd0, if0.digit_idx}, 32'd4);
    td  = 24'h123456;
    rst = 1'b1;
    #1;
    check("rstm_seg_lo", {25'd0, if1.seg}, 32'h7F);
    check("rstm_dig_lo", {26'd0, if1.dig}, 32'h3F);
    check("rstm_idx",    {29'd0, if1.digit_idx}, 32'd0);
    check("rstm_dp_lo",  {31'd0, if1.dp}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        check("rel_idx_hold", {29'd0, if0.digit_idx}, 32'd0);
        check("rel_dig_off",  {26'd0, if1.dig}, 32'h3F);
      end else begin
        check("rel_first_tick", {29'd0, if0.digit_idx}, 32'd1);
        check("rel_seg_snap0",  {25'd0, if1.seg}, 32'h40);
        check("rel_dig_lo",     {26'd0, if1.dig}, 32'h3D);
      end
    end

`ifdef DISP_DP_BLINK_EN
    blink_td = '{24'h000000, 24'h000001, 24'h000001, 24'h000002};
    blink_dp = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int f = 0; f < 4; f++) begin
      td = blink_td[f];
      for (int i = 0; i < 7 && if0.digit_idx != 3'd0; i++) next_tick();
      check("blink_sync", {29'd0, if0.digit_idx}, 32'd0);
      next_tick();
      next_tick();
      check("blink_dp_d2", {31'd0, if0.dp}, {31'd0, blink_dp[f]});
      next_tick();
      next_tick();
      check("blink_dp_d4", {31'd0, if0.dp}, {31'd0, blink_dp[f]});
      check("blink_dp_lo", {31'd0, if1.dp}, {31'd0, ~blink_dp[f]});
    end
`else
    blink_td = '{24'h0, 24'h0, 24'h0, 24'h0};
    blink_dp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
